// File: rtl/bmp_word_unpacker_if.sv
// ---------------------------------------------------------------------------
// bmp_word_unpacker_if
// Handshake bundle for the BMP word unpacker.
//   Word side : in_valid, in_data (DATA_BUS_SIZE bits, 4 file bytes per
//               32-bit word, byte 4k+i in bits [8i+7:8i]), in_ready
//   Pixel side: pix_valid, pix_data (8 bits), pix_ready, pix_last
// Modports:
//   slave  - the unpacker (consumes words, produces pixel bytes)
//   master - the environment (produces words, consumes pixel bytes)
// ---------------------------------------------------------------------------
interface bmp_word_unpacker_if #(
   parameter int DATA_BUS_SIZE = 32
);
   logic                     in_valid;
   logic [DATA_BUS_SIZE-1:0] in_data;
   logic                     in_ready;
   logic                     pix_valid;
   logic [7:0]               pix_data;
   logic                     pix_ready;
   logic                     pix_last;

   modport slave (
      input  in_valid, in_data, pix_ready,
      output in_ready, pix_valid, pix_data, pix_last
   );

   modport master (
      output in_valid, in_data, pix_ready,
      input  in_ready, pix_valid, pix_data, pix_last
   );
endinterface

// File: rtl/bmp_word_unpacker.sv
// ---------------------------------------------------------------------------
// bmp_word_unpacker
// Receive end of the BMP word stream. Buffers one input word, walks its
// bytes one per cycle, parses the 30-byte BMP header, discards the gap up to
// data_start and presents pixel bytes on a valid/ready port. Padding bytes
// that follow the last file byte in the final word are dropped.
//
// Ports
//   clk, rst_n   clock (rising edge) / asynchronous active-low reset
//   bus          bmp_word_unpacker_if.slave: word input + pixel output
//   hdr_valid    header fields stable (set after byte 29, cleared on done)
//   file_size    bytes 5..2     data_start bytes 13..10
//   p_width      bytes 21..18   p_height   bytes 25..22
//   bit_count    bytes 29..28
//   done         one-cycle pulse after the last file byte is consumed
//   hdr_err      sticky header error, cleared only by reset
//
// Optional build macro
//   BMP_SIG_CHECK_EN : bytes 0,1 must read "BM"; a mismatch enters the
//                      error state as soon as byte 1 is consumed.
// ---------------------------------------------------------------------------
module bmp_word_unpacker #(
   parameter int DATA_BUS_SIZE = 32,
   parameter int CNT_W         = 32,
   parameter int HDR_LEN       = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   bmp_word_unpacker_if.slave bus,
   output logic              hdr_valid,
   output logic [CNT_W-1:0]  file_size,
   output logic [CNT_W-1:0]  data_start,
   output logic [CNT_W-1:0]  p_width,
   output logic [CNT_W-1:0]  p_height,
   output logic [15:0]       bit_count,
   output logic              done,
   output logic              hdr_err
);

   localparam int BPW   = DATA_BUS_SIZE / 8;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

   typedef enum logic [2:0] {S_HDR, S_SKIP, S_PIX, S_DONE, S_ERR} state_t;

   state_t                   state_q, state_d;
   logic                     run_q, run_d;
   logic [DATA_BUS_SIZE-1:0] buf_q, buf_d;
   logic                     buf_full_q, buf_full_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0]         file_size_q, file_size_d;
   logic [CNT_W-1:0]         data_start_q, data_start_d;
   logic [CNT_W-1:0]         p_width_q, p_width_d;
   logic [CNT_W-1:0]         p_height_q, p_height_d;
   logic [15:0]              bit_count_q, bit_count_d;
   logic                     hdr_valid_q, hdr_valid_d;
   logic                     hdr_err_q, hdr_err_d;
`ifdef BMP_SIG_CHECK_EN
   logic                     sig0_ok_q, sig0_ok_d;
`endif

   logic [7:0] cur_byte;
   logic [4:0] hdr_pos;
   logic       pix_valid_w;
   logic       pix_last_w;
   logic       consume;
   logic       last_in_word;
   logic       in_ready_w;
   logic       load;

   // Replace byte lane 'lane' of a little-endian header field.
   function automatic logic [CNT_W-1:0] put_byte(input logic [CNT_W-1:0] v,
                                                 input int lane,
                                                 input logic [7:0] b);
      logic [CNT_W-1:0] r;
      r = v;
      for (int i = 0; i < CNT_W; i++) begin
         if ((i / 8) == lane) r[i] = b[3'(i % 8)];
      end
      return r;
   endfunction

   // Byte currently addressed inside the word buffer.
   always_comb begin
      cur_byte = 8'h00;
      for (int i = 0; i < BPW; i++) begin
         if (idx_q == IDX_W'(i)) cur_byte = buf_q[8*i +: 8];
      end
   end

   // Header offsets only matter while byte_cnt < HDR_LEN, so 5 bits suffice.
   assign hdr_pos      = byte_cnt_q[4:0];
   assign last_in_word = (idx_q == IDX_LAST);
   assign pix_valid_w  = (state_q == S_PIX) & buf_full_q;
   assign pix_last_w   = pix_valid_w & (byte_cnt_q == (file_size_q - CNT_W'(1)));

   always_comb begin
      unique case (state_q)
         S_HDR, S_SKIP: consume = buf_full_q;
         S_PIX:         consume = pix_valid_w & bus.pix_ready;
         default:       consume = 1'b0;
      endcase
   end

   // run_q keeps in_ready low through reset and the first cycle after it.
   // The final pixel byte never refills the buffer: DONE clears it, so a
   // word accepted on that edge would belong to the next file and be lost.
   always_comb begin
      unique case (state_q)
         S_ERR:   in_ready_w = run_q;
         S_DONE:  in_ready_w = 1'b0;
         S_PIX:   in_ready_w = run_q & (~buf_full_q | (consume & last_in_word & ~pix_last_w));
         default: in_ready_w = run_q & (~buf_full_q | (consume & last_in_word));
      endcase
   end

   assign load = bus.in_valid & in_ready_w;

   always_comb begin
      state_d      = state_q;
      run_d        = 1'b1;
      buf_d        = buf_q;
      buf_full_d   = buf_full_q;
      idx_d        = idx_q;
      byte_cnt_d   = byte_cnt_q;
      file_size_d  = file_size_q;
      data_start_d = data_start_q;
      p_width_d    = p_width_q;
      p_height_d   = p_height_q;
      bit_count_d  = bit_count_q;
      hdr_valid_d  = hdr_valid_q;
      hdr_err_d    = hdr_err_q;
`ifdef BMP_SIG_CHECK_EN
      sig0_ok_d    = sig0_ok_q;
`endif

      // Word buffer: advance on consume, refill on accept.
      if (consume) begin
         byte_cnt_d = byte_cnt_q + CNT_W'(1);
         if (last_in_word) begin
            idx_d      = '0;
            buf_full_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (load) begin
         buf_d      = bus.in_data;
         buf_full_d = 1'b1;
         idx_d      = '0;
      end

      unique case (state_q)
         S_HDR: begin
            if (consume) begin
               case (hdr_pos)
`ifdef BMP_SIG_CHECK_EN
                  5'd0: sig0_ok_d = (cur_byte == 8'h42);
                  5'd1: begin
                     if (!(sig0_ok_q && (cur_byte == 8'h4D))) begin
                        state_d     = S_ERR;
                        hdr_err_d   = 1'b1;
                        buf_full_d  = 1'b0;
                        idx_d       = '0;
                     end
                  end
`endif
                  5'd2, 5'd3, 5'd4, 5'd5:
                     file_size_d = put_byte(file_size_q, int'(hdr_pos) - 2, cur_byte);
                  5'd10, 5'd11, 5'd12, 5'd13:
                     data_start_d = put_byte(data_start_q, int'(hdr_pos) - 10, cur_byte);
                  5'd18, 5'd19, 5'd20, 5'd21:
                     p_width_d = put_byte(p_width_q, int'(hdr_pos) - 18, cur_byte);
                  5'd22, 5'd23, 5'd24, 5'd25:
                     p_height_d = put_byte(p_height_q, int'(hdr_pos) - 22, cur_byte);
                  5'd28: bit_count_d[7:0] = cur_byte;
                  5'd29: begin
                     bit_count_d[15:8] = cur_byte;
                     if ((file_size_q < CNT_W'(HDR_LEN)) ||
                         (data_start_q < CNT_W'(HDR_LEN)) ||
                         (data_start_q >= file_size_q)) begin
                        state_d    = S_ERR;
                        hdr_err_d  = 1'b1;
                        buf_full_d = 1'b0;
                        idx_d      = '0;
                     end else begin
                        hdr_valid_d = 1'b1;
                        state_d     = (data_start_q == CNT_W'(HDR_LEN)) ? S_PIX : S_SKIP;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_SKIP: begin
            // Leave on the edge that consumes byte data_start-1 so the first
            // pixel is presented without a bubble.
            if (consume && ((byte_cnt_q + CNT_W'(1)) == data_start_q)) state_d = S_PIX;
         end
         S_PIX: begin
            if (consume && pix_last_w) state_d = S_DONE;
         end
         S_DONE: begin
            state_d     = S_HDR;
            hdr_valid_d = 1'b0;
            byte_cnt_d  = '0;
            buf_d       = '0;
            buf_full_d  = 1'b0;
            idx_d       = '0;
         end
         S_ERR: begin
            buf_d      = buf_q;
            buf_full_d = 1'b0;
            idx_d      = '0;
         end
         default: state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_HDR;
         run_q        <= 1'b0;
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         idx_q        <= '0;
         byte_cnt_q   <= '0;
         file_size_q  <= '0;
         data_start_q <= '0;
         p_width_q    <= '0;
         p_height_q   <= '0;
         bit_count_q  <= '0;
         hdr_valid_q  <= 1'b0;
         hdr_err_q    <= 1'b0;
`ifdef BMP_SIG_CHECK_EN
         sig0_ok_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         idx_q        <= idx_d;
         byte_cnt_q   <= byte_cnt_d;
         file_size_q  <= file_size_d;
         data_start_q <= data_start_d;
         p_width_q    <= p_width_d;
         p_height_q   <= p_height_d;
         bit_count_q  <= bit_count_d;
         hdr_valid_q  <= hdr_valid_d;
         hdr_err_q    <= hdr_err_d;
`ifdef BMP_SIG_CHECK_EN
         sig0_ok_q    <= sig0_ok_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.pix_valid = pix_valid_w;
   assign bus.pix_data  = pix_valid_w ? cur_byte : 8'h00;
   assign bus.pix_last  = pix_last_w;
   assign hdr_valid     = hdr_valid_q;
   assign file_size     = file_size_q;
   assign data_start    = data_start_q;
   assign p_width       = p_width_q;
   assign p_height      = p_height_q;
   assign bit_count     = bit_count_q;
   assign done          = (state_q == S_DONE);
   assign hdr_err       = hdr_err_q;

endmodule

// File: tb/tb_bmp_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_bmp_word_unpacker
// Randomized scoreboard bench. Each file is generated as a byte array; the
// expected pixel stream (bytes data_start..file_size-1, last flag on the
// final one, header fields) is queued when the file is issued, and an
// independent monitor pops and compares on every pixel handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bmp_word_unpacker;
   localparam int DW  = 32;
   localparam int CW  = 32;
   localparam int BPW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bmp_word_unpacker_if #(.DATA_BUS_SIZE(DW)) bus ();

   logic          hdr_valid;
   logic [CW-1:0] file_size, data_start, p_width, p_height;
   logic [15:0]   bit_count;
   logic          done, hdr_err;

   bmp_word_unpacker #(.DATA_BUS_SIZE(DW), .CNT_W(CW), .HDR_LEN(30)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .hdr_valid(hdr_valid), .file_size(file_size), .data_start(data_start),
      .p_width(p_width), .p_height(p_height), .bit_count(bit_count),
      .done(done), .hdr_err(hdr_err)
   );

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [31:0] fs, ds, w, h;
      logic [15:0] bc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] file_bytes[$];
   int         checks = 0;
   int         failures = 0;
   int         done_seen = 0;
   int         pix_cnt = 0;
   int         rdy_mode = 0;
   bit         abort = 0;
   bit         prev_last = 0;
   bit         stall_pending = 0;
   logic [7:0] stall_data = 8'h00;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endfunction

   // Build a file: header fields at their offsets, pixels from data_start.
   task automatic build_file(input int nbytes, input logic [31:0] fs, ds, w, h,
                             input logic [15:0] bc, input logic [7:0] sig0, input bit ramp);
      logic [7:0] b;
      file_bytes.delete();
      for (int i = 0; i < nbytes; i++) begin
         b = 8'($urandom);
         if (i == 0) b = sig0;
         else if (i == 1) b = 8'h4D;
         else if (i >= 2 && i <= 5) b = fs[8*(i-2) +: 8];
         else if (i >= 10 && i <= 13) b = ds[8*(i-10) +: 8];
         else if (i >= 14 && i <= 17) b = (i == 14) ? 8'd40 : 8'd0;
         else if (i >= 18 && i <= 21) b = w[8*(i-18) +: 8];
         else if (i >= 22 && i <= 25) b = h[8*(i-22) +: 8];
         else if (i == 26) b = 8'd1;
         else if (i == 27) b = 8'd0;
         else if (i == 28) b = bc[7:0];
         else if (i == 29) b = bc[15:8];
         else if (i >= int'(ds) && ramp) b = 8'(i - int'(ds));
         file_bytes.push_back(b);
      end
   endtask

   task automatic expect_pixels(input logic [31:0] fs, ds, w, h, input logic [15:0] bc);
      exp_t e;
      for (int i = int'(ds); i < int'(fs); i++) begin
         e.data = file_bytes[i];
         e.last = (i == int'(fs) - 1);
         e.fs = fs; e.ds = ds; e.w = w; e.h = h; e.bc = bc;
         exp_q.push_back(e);
      end
   endtask

   // Entered at posedge+1; leaves at posedge+1 after the word is taken.
   task automatic push_word(input logic [DW-1:0] w);
      logic hs;
      int   t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      forever begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         if (abort || hs) break;
         t++;
         if (t > 1000) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout word=%h waited=%0d cycles", w, t);
            abort = 1;
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_bytes(input int gapmax);
      int n;
      logic [DW-1:0] w;
      n = file_bytes.size();
      for (int base = 0; base < n; base += BPW) begin
         if (abort) return;
         for (int j = 0; j < BPW; j++)
            w[8*j +: 8] = (base + j < n) ? file_bytes[base+j] : 8'($urandom);
         repeat ($urandom_range(0, gapmax)) begin
            @(posedge clk);
            #1;
         end
         push_word(w);
      end
   endtask

   task automatic run_file(input logic [31:0] fs, ds, w, h, input logic [15:0] bc,
                           input logic [7:0] sig0, input bit ramp, input int gapmax);
      build_file(int'(fs), fs, ds, w, h, bc, sig0, ramp);
      expect_pixels(fs, ds, w, h, bc);
      send_bytes(gapmax);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0) && (t < 3000)) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk({name, "_drain_left"}, exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_in_ready"},   bus.in_ready, 0);
      chk({name, "_pix_valid"},  bus.pix_valid, 0);
      chk({name, "_pix_data"},   bus.pix_data, 0);
      chk({name, "_pix_last"},   bus.pix_last, 0);
      chk({name, "_hdr_fields"}, {hdr_valid, file_size, data_start} | {p_width, p_height}, 0);
      chk({name, "_bit_count"},  bit_count, 0);
      chk({name, "_done_err"},   {done, hdr_err}, 0);
   endtask

   // Pixel-ready pattern generator.
   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = ~bus.pix_ready;
            default: bus.pix_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_last     = 0;
         stall_pending = 0;
      end else begin
         if (done || prev_last) chk("done_after_last", done, prev_last);
         if (done) done_seen++;
         prev_last = 0;
         if (stall_pending) begin
            chk("stall_hold_valid", bus.pix_valid, 1);
            chk("stall_hold_data", bus.pix_data, stall_data);
            stall_pending = 0;
         end
         if (bus.pix_valid && !bus.pix_ready) begin
            stall_pending = 1;
            stall_data    = bus.pix_data;
            chk("stall_in_ready_low", bus.in_ready, 0);
         end
         if (bus.pix_valid && bus.pix_ready) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
               chk("pix_unexpected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("pix_data", bus.pix_data, e.data);
               chk("pix_last", bus.pix_last, e.last);
               chk("hdr_valid", hdr_valid, 1);
               chk("hdr_fs_ds", {file_size, data_start}, {e.fs, e.ds});
               chk("hdr_w_h", {p_width, p_height}, {e.w, e.h});
               chk("hdr_bc", bit_count, e.bc);
            end
            prev_last = bus.pix_last;
         end
      end
   end

   initial begin
      #600000;
      checks++; failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int d0, p0, ds_r, np;
      logic [15:0] bcs[4];
      bcs[0] = 16'd1; bcs[1] = 16'd4; bcs[2] = 16'd8; bcs[3] = 16'd24;

      // T1 reset
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk("in_ready_before_edge", bus.in_ready, 0);
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", bus.in_ready, 1);

      // T2 nominal
      rdy_mode = 0;
      d0 = done_seen;
      run_file(70, 54, 640, 480, 24, 8'h42, 1, 0);
      wait_drain("t2");
      chk("t2_done_count", done_seen - d0, 1);
      chk("t2_hdr_err", hdr_err, 0);
      chk("t2_hdr_valid_cleared", hdr_valid, 0);

      // T3 backpressure
      rdy_mode = 1;
      d0 = done_seen;
      run_file(70, 54, 17, 9, 8, 8'h42, 1, 0);
      wait_drain("t3");
      chk("t3_done_count", done_seen - d0, 1);

      // T6 back-to-back
      rdy_mode = 0;
      d0 = done_seen;
      p0 = pix_cnt;
      run_file(70, 54, 4, 4, 8, 8'h42, 1, 0);
      run_file(70, 54, 3, 5, 24, 8'h42, 1, 0);
      wait_drain("t6");
      chk("t6_done_count", done_seen - d0, 2);
      chk("t6_pix_count", pix_cnt - p0, 32);
      chk("t6_hdr_err", hdr_err, 0);

      // Random files: data_start 30..60, 1..20 pixels, random ready
      rdy_mode = 2;
      d0 = done_seen;
      for (int k = 0; k < 8; k++) begin
         ds_r = $urandom_range(30, 60);
         np   = $urandom_range(1, 20);
         run_file(32'(ds_r + np), 32'(ds_r), 32'($urandom_range(1, 4000)),
                  32'($urandom_range(1, 4000)), bcs[$urandom_range(0, 3)], 8'h42, 0, 2);
      end
      wait_drain("rand");
      chk("rand_done_count", done_seen - d0, 8);
      chk("rand_hdr_err", hdr_err, 0);

`ifndef BMP_SIG_CHECK_EN
      // Signature bytes are ignored in this build
      rdy_mode = 0;
      d0 = done_seen;
      run_file(40, 30, 2, 5, 8, 8'h41, 1, 1);
      wait_drain("nosig");
      chk("nosig_done_count", done_seen - d0, 1);
      chk("nosig_hdr_err", hdr_err, 0);
`endif

      // T5 mid-file reset
      rdy_mode = 0;
      p0 = pix_cnt;
      abort = 0;
      fork
         run_file(70, 54, 640, 480, 24, 8'h42, 1, 0);
         begin
            int t;
            t = 0;
            while ((pix_cnt < p0 + 5) && (t < 3000)) begin
               @(negedge clk);
               t++;
            end
            chk("t5_reached_pix", pix_cnt >= p0 + 5, 1);
            @(posedge clk);
            #1;
            abort = 1;
            rst_n = 1'b0;
            @(negedge clk);
            chk_zero_outputs("t5_reset");
         end
      join
      exp_q.delete();
      @(posedge clk);
      #1;
      abort = 0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      d0 = done_seen;
      run_file(70, 54, 100, 200, 24, 8'h42, 1, 0);
      wait_drain("t5_after");
      chk("t5_done_count", done_seen - d0, 1);

      // T4 size error: file_size=20
      p0 = pix_cnt;
      build_file(40, 20, 54, 1, 1, 8, 8'h42, 1);
      send_bytes(0);
      repeat (4) @(negedge clk);
      chk("t4_hdr_err", hdr_err, 1);
      chk("t4_pix_valid", bus.pix_valid, 0);
      chk("t4_hdr_valid", hdr_valid, 0);
      chk("t4_in_ready", bus.in_ready, 1);
      chk("t4_no_pixels", pix_cnt - p0, 0);

`ifdef BMP_SIG_CHECK_EN
      // Bad signature: error after byte 1, first word only
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("sig_err_clear", hdr_err, 0);
      build_file(4, 70, 54, 1, 1, 8, 8'h41, 1);
      send_bytes(0);
      repeat (3) @(negedge clk);
      chk("sig_hdr_err", hdr_err, 1);
      chk("sig_pix_valid", bus.pix_valid, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
